// File: rtl/mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// mem_bridge_pkg
//   Shared types and constants for the byte-serial memory bridge that sits
//   between the multicycle RV32I memory port and an 8-bit physical memory.
//
//   Contents:
//     NUM_LANES       byte lanes per CPU word (4 for RV32I)
//     LANE_IDX_W      width of a lane index
//     bridge_state_t  bridge FSM states: IDLE, ACCESS, DONE
//     bridge_op_t     latched operation: BR_READ, BR_WRITE
//     lane_bit()      one-hot mask bit for a lane index
// -----------------------------------------------------------------------------
package mem_bridge_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bridge_state_t;

    typedef enum logic {
        BR_READ  = 1'b0,
        BR_WRITE = 1'b1
    } bridge_op_t;

    // One-hot bit for a lane, used to retire that lane from the remaining mask.
    function automatic logic [NUM_LANES-1:0] lane_bit(input logic [LANE_IDX_W-1:0] idx);
        return NUM_LANES'(1) << idx;
    endfunction

endpackage

// File: rtl/byte_serial_mem_bridge_lowest_set_lane.sv
// -----------------------------------------------------------------------------
// lowest_set_lane
//   Combinational 4-to-2 priority encoder. Picks the lowest-numbered lane
//   still pending in the mask so beats are issued in ascending byte order.
//
//   Ports:
//     mask   in   NUM_LANES   lanes still to be transferred
//     idx    out  LANE_IDX_W  lowest set lane (0 when mask is empty)
//     valid  out  1           mask has at least one bit set
// -----------------------------------------------------------------------------
module lowest_set_lane
    import mem_bridge_pkg::*;
(
    input  logic [NUM_LANES-1:0]  mask,
    output logic [LANE_IDX_W-1:0] idx,
    output logic                  valid
);

    // Scan from the top down so the last hit, the lowest lane, wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through it can infer a latch.
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = LANE_IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_serial_mem_bridge.sv
// -----------------------------------------------------------------------------
// byte_serial_mem_bridge
//   Takes one 32-bit word request at a time from the multicycle RV32I memory
//   port and replays it to an 8-bit physical memory as one byte beat per
//   enabled lane, lowest lane first. Read bytes are reassembled into a word
//   and the CPU sees a single-cycle mem_resp when the whole word is done.
//
//   Ports:
//     clk              in   1       clock
//     rst              in   1       synchronous active-high reset
//     mem_address      in   ADDR_W  CPU byte address, bits [1:0] ignored
//     mem_read         in   1       CPU read request, held until mem_resp
//     mem_write        in   1       CPU write request, held until mem_resp
//     mem_byte_enable  in   4       lanes to access
//     mem_wdata        in   32      lane-aligned store data
//     mem_rdata        out  32      assembled load data, held between reads
//     mem_resp         out  1       one-cycle completion pulse
//     pmem_address     out  ADDR_W  byte address of the current beat
//     pmem_read        out  1       physical read strobe
//     pmem_write       out  1       physical write strobe
//     pmem_wdata       out  8       byte of the current beat
//     pmem_rdata       in   8       returned byte, valid with pmem_resp
//     pmem_resp        in   1       current beat complete
// -----------------------------------------------------------------------------
module byte_serial_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int NUM_LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [ADDR_W-1:0]      mem_address,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [NUM_LANES-1:0]   mem_byte_enable,
    input  logic [8*NUM_LANES-1:0] mem_wdata,
    output logic [8*NUM_LANES-1:0] mem_rdata,
    output logic                   mem_resp,

    output logic [ADDR_W-1:0]      pmem_address,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [7:0]             pmem_wdata,
    input  logic [7:0]             pmem_rdata,
    input  logic                   pmem_resp
);

    // ------------------------------------------------------------------
    // Latched request and working state
    // ------------------------------------------------------------------
    bridge_state_t          state;
    bridge_state_t          state_next;

    logic [ADDR_W-3:0]      word_addr;
    logic [NUM_LANES-1:0]   mask;
    logic [8*NUM_LANES-1:0] wdata;
    bridge_op_t             op;
    logic [8*NUM_LANES-1:0] acc;

    logic                   req;
    bridge_op_t             req_op;
    logic [LANE_IDX_W-1:0]  lane_idx;
    logic                   lane_valid;
    logic [NUM_LANES-1:0]   mask_remaining;
    logic [8*NUM_LANES-1:0] acc_merged;

    // The request is word-aligned; the byte offset bits carry no meaning here.
    logic                   addr_offset_unused;
    assign addr_offset_unused = ^mem_address[1:0];

    // A simultaneous read and write is serviced as a write.
    assign req    = mem_read | mem_write;
    assign req_op = mem_write ? BR_WRITE : BR_READ;

    lowest_set_lane u_lowest_set_lane (
        .mask  (mask),
        .idx   (lane_idx),
        .valid (lane_valid)
    );

    // Mask after the current beat retires, and the accumulator with the
    // returned byte dropped into the current lane.
    assign mask_remaining = mask & ~lane_bit(lane_idx);

    always_comb begin
        acc_merged                         = acc;
        acc_merged[{lane_idx, 3'b000} +: 8] = pmem_rdata;
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs. The physical strobes are decoded purely
    // from state and latched registers so they hold steady for the whole
    // beat, however long the memory takes to answer.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;

        unique case (state)
            IDLE: begin
                if (req) begin
                    state_next = (mem_byte_enable == '0) ? DONE : ACCESS;
                end
            end

            ACCESS: begin
                pmem_address = {word_addr, lane_idx};
                pmem_wdata   = wdata[{lane_idx, 3'b000} +: 8];
                pmem_read    = lane_valid && (op == BR_READ);
                pmem_write   = lane_valid && (op == BR_WRITE);
                // The next lane is presented on the very next cycle, so a
                // multi-lane access has no bubble between beats.
                if (pmem_resp && (mask_remaining == '0)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                // The CPU drops its strobe only after seeing mem_resp, so the
                // IDLE cycle that follows keeps the same request from being
                // accepted twice.
                mem_resp   = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, lane mask, read accumulator and returned word
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: every holding register is reset, so a reset in the middle of
        // a beat leaves no stale lane mask, op or data to be replayed.
        if (rst) begin
            word_addr <= '0;
            mask      <= '0;
            wdata     <= '0;
            op        <= BR_READ;
            acc       <= '0;
            mem_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so each register
            // sees the values from before this edge regardless of order.
            unique case (state)
                IDLE: begin
                    if (req) begin
                        word_addr <= mem_address[ADDR_W-1:2];
                        mask      <= mem_byte_enable;
                        wdata     <= mem_wdata;
                        op        <= req_op;
                        acc       <= '0;
                        // A read with no lanes completes straight away and
                        // returns an all-zero word.
                        if ((mem_byte_enable == '0) && (req_op == BR_READ)) begin
                            mem_rdata <= '0;
                        end
                    end
                end

                ACCESS: begin
                    if (pmem_resp) begin
                        mask <= mask_remaining;
                        if (op == BR_READ) begin
                            acc <= acc_merged;
                            // Publish the word on the way into DONE so it is
                            // already valid while mem_resp is high.
                            if (mask_remaining == '0) begin
                                mem_rdata <= acc_merged;
                            end
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_byte_serial_mem_bridge
//   Directed bench for byte_serial_mem_bridge. A byte-array memory answers
//   each physical beat after a programmable latency; a transaction-level
//   model derives, per cycle, which beat must be on the bus, when mem_resp
//   must fire and what mem_rdata must hold. Literal expectations from the
//   worked examples pin the model.
// -----------------------------------------------------------------------------
module tb_byte_serial_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic [31:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [7:0]  pmem_wdata;
    logic [7:0]  pmem_rdata = 8'h00;
    logic        pmem_resp  = 1'b0;

    always #5 clk = ~clk;

    byte_serial_mem_bridge #(
        .ADDR_W    (32),
        .NUM_LANES (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Physical memory contents (bench view) and beat log
    logic [7:0]  mem [0:1023];
    int          lat        = 1;
    bit          idle_noise = 1'b0;
    int          beat_cnt   = 0;
    logic [31:0] log_addr [$];
    logic [7:0]  log_wd   [$];
    bit          log_wr   [$];

    // Transaction model
    bit          checking = 1'b0;
    bit          m_on     = 1'b0;
    int          m_cyc    = 0;
    logic [31:0] m_addr   = '0;
    bit          m_write  = 1'b0;
    logic [3:0]  m_mbe    = '0;
    logic [31:0] m_wdata  = '0;
    int          m_lanes [$];
    int          m_n      = 0;
    logic [31:0] m_exp_rdata = '0;
    logic [31:0] m_rdata  = '0;
    bit          resp_seen = 1'b0;
    int          resp_cyc  = -1;
    int          rd_cycles = 0;
    int          wr_cycles = 0;

    // Per-cycle compare, then the physical memory responder.
    always @(negedge clk) begin
        logic        e_rd;
        logic        e_wr;
        logic        e_resp;
        logic [31:0] e_addr;
        logic [7:0]  e_wd;
        int          k;
        e_rd = 1'b0; e_wr = 1'b0; e_resp = 1'b0; e_addr = '0; e_wd = '0; k = 0;

        if (checking) begin
            if (m_on) begin
                if (m_cyc >= 1 && m_cyc <= m_n * lat) begin
                    k      = (m_cyc - 1) / lat;
                    e_addr = {m_addr[31:2], 2'(m_lanes[k])};
                    e_wd   = m_wdata[8*m_lanes[k] +: 8];
                    e_wr   = m_write;
                    e_rd   = !m_write;
                end else if (m_cyc == 1 + m_n * lat) begin
                    e_resp = 1'b1;
                    if (!m_write) m_rdata = m_exp_rdata;
                end
            end
            check("mem_resp",   mem_resp,   e_resp);
            check("pmem_read",  pmem_read,  e_rd);
            check("pmem_write", pmem_write, e_wr);
            check("mem_rdata",  mem_rdata,  m_rdata);
            if (e_rd || e_wr) check("pmem_address", pmem_address, e_addr);
            if (e_wr)         check("pmem_wdata",   pmem_wdata,   e_wd);
            if (pmem_read)  rd_cycles++;
            if (pmem_write) wr_cycles++;
            if (e_resp) begin
                resp_seen = 1'b1;
                resp_cyc  = m_cyc;
                m_on      = 1'b0;
            end
            if (m_on) m_cyc++;
            if (rst) begin
                m_on    = 1'b0;
                m_rdata = '0;
            end
        end

        if (pmem_read || pmem_write) begin
            beat_cnt++;
            if (beat_cnt >= lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = pmem_read ? mem[pmem_address[9:0]] : 8'h00;
                log_addr.push_back(pmem_address);
                log_wd.push_back(pmem_wdata);
                log_wr.push_back(pmem_write);
                beat_cnt = 0;
            end else begin
                pmem_resp  = 1'b0;
                pmem_rdata = 8'hA5;
            end
        end else begin
            beat_cnt   = 0;
            pmem_resp  = idle_noise;
            pmem_rdata = 8'hFF;
        end
    end

    // Present a request in an IDLE cycle and arm the model.
    task automatic start_req(input logic [31:0] addr, input bit rd, input bit wr,
                             input logic [3:0] mbe, input logic [31:0] wd);
        logic [31:0] exp_word;
        exp_word = '0;
        m_lanes.delete();
        for (int l = 0; l < 4; l++) begin
            if (mbe[l]) begin
                m_lanes.push_back(l);
                exp_word[8*l +: 8] = mem[{addr[9:2], 2'(l)}];
            end
        end
        m_n = m_lanes.size();
        m_addr = addr; m_write = wr; m_mbe = mbe; m_wdata = wd; m_exp_rdata = exp_word;
        resp_seen = 1'b0; resp_cyc = -1; rd_cycles = 0; wr_cycles = 0;
        log_addr.delete(); log_wd.delete(); log_wr.delete();
        @(posedge clk); #1;
        mem_address = addr; mem_read = rd; mem_write = wr;
        mem_byte_enable = mbe; mem_wdata = wd;
        m_cyc = 0;
        m_on  = 1'b1;
    endtask

    // Hold the strobe until mem_resp, drop it the next cycle, update memory.
    task automatic finish_req();
        for (int i = 0; i < 200 && !resp_seen; i++) begin
            @(posedge clk); #1;
        end
        check("resp_seen", resp_seen, 1'b1);
        m_on = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        if (m_write) begin
            for (int l = 0; l < 4; l++)
                if (m_mbe[l]) mem[{m_addr[9:2], 2'(l)}] = m_wdata[8*l +: 8];
        end
    endtask

    task automatic run_req(input logic [31:0] addr, input bit rd, input bit wr,
                           input logic [3:0] mbe, input logic [31:0] wd);
        start_req(addr, rd, wr, mbe, wd);
        finish_req();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst = 1'b1;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checking = 1'b1;

        // Reset state
        check("rst_mem_resp",     mem_resp,     1'b0);
        check("rst_mem_rdata",    mem_rdata,    32'h0);
        check("rst_pmem_read",    pmem_read,    1'b0);
        check("rst_pmem_write",   pmem_write,   1'b0);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_pmem_wdata",   pmem_wdata,   8'h00);

        // Word read at a misaligned address, 2-cycle beats
        lat = 2;
        mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
        run_req(32'h0000_0103, 1'b1, 1'b0, 4'b1111, 32'h0);
        check("word_rd_rdata",    mem_rdata, 32'h4433_2211);
        check("word_rd_resp_cyc", resp_cyc,  9);
        check("word_rd_beats",    log_addr.size(), 4);
        for (int i = 0; i < 4; i++) check("word_rd_addr", log_addr[i], 32'h100 + i);
        check("word_rd_rd_cycles", rd_cycles, 8);
        check("word_rd_wr_cycles", wr_cycles, 0);

        // Single byte write to lane 2
        lat = 1;
        run_req(32'h0000_0200, 1'b0, 1'b1, 4'b0100, 32'h00AB_0000);
        check("byte_wr_beats",     log_addr.size(), 1);
        check("byte_wr_addr",      log_addr[0], 32'h202);
        check("byte_wr_wdata",     log_wd[0],   8'hAB);
        check("byte_wr_is_write",  log_wr[0],   1'b1);
        check("byte_wr_rd_cycles", rd_cycles,   0);
        check("byte_wr_resp_cyc",  resp_cyc,    2);
        check("byte_wr_rdata_kept", mem_rdata,  32'h4433_2211);

        // Upper half read, disabled lanes return zero
        lat = 3;
        mem[10'h300] = 8'h55; mem[10'h301] = 8'h66; mem[10'h302] = 8'hEF; mem[10'h303] = 8'hBE;
        run_req(32'h0000_0300, 1'b1, 1'b0, 4'b1100, 32'h0);
        check("half_rd_rdata",    mem_rdata,   32'hBEEF_0000);
        check("half_rd_addr0",    log_addr[0], 32'h302);
        check("half_rd_addr1",    log_addr[1], 32'h303);
        check("half_rd_resp_cyc", resp_cyc,    7);

        // Read with no lanes enabled
        run_req(32'h0000_0300, 1'b1, 1'b0, 4'b0000, 32'h0);
        check("zero_rd_resp_cyc", resp_cyc,  1);
        check("zero_rd_rdata",    mem_rdata, 32'h0);
        check("zero_rd_strobes",  rd_cycles + wr_cycles, 0);

        // Back-to-back requests with stray pmem_resp outside beats
        lat = 1;
        idle_noise = 1'b1;
        run_req(32'h0000_0100, 1'b1, 1'b0, 4'b1111, 32'h0);
        check("b2b_first_rdata", mem_rdata, 32'h4433_2211);
        run_req(32'h0000_0200, 1'b1, 1'b0, 4'b0100, 32'h0);
        check("b2b_second_rdata", mem_rdata, 32'h00AB_0000);
        check("b2b_second_beats", log_addr.size(), 1);
        run_req(32'h0000_0080, 1'b1, 1'b1, 4'b0001, 32'h0000_005A);
        check("rdwr_is_write",  log_wr[0], 1'b1);
        check("rdwr_rd_cycles", rd_cycles, 0);
        idle_noise = 1'b0;

        // Reset during the second beat of a 4-byte write
        lat = 2;
        start_req(32'h0000_0040, 1'b0, 1'b1, 4'b1111, 32'hA1B2_C3D4);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        mem_write = 1'b0;
        @(negedge clk);
        check("rst_mid_beat2_addr",  pmem_address, 32'h41);
        check("rst_mid_beat2_write", pmem_write,   1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_write_drop", pmem_write, 1'b0);
        check("rst_mid_rdata",      mem_rdata,  32'h0);
        repeat (4) @(negedge clk);
        check("rst_mid_no_resp",   resp_seen,       1'b0);
        check("rst_mid_beats",     log_addr.size(), 1);
        check("rst_mid_beat1_wd",  log_wd[0],       8'hD4);
        m_on = 1'b0;
        mem[10'h040] = 8'hD4;

        // Fresh traffic after reset
        lat = 1;
        run_req(32'h0000_0040, 1'b0, 1'b1, 4'b1111, 32'h0BAD_F00D);
        check("post_rst_wr_rdata_kept", mem_rdata, 32'h0);
        run_req(32'h0000_0040, 1'b1, 1'b0, 4'b1111, 32'h0);
        check("post_rst_rd_rdata", mem_rdata, 32'h0BAD_F00D);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
